pc_ras_gen: RTL

//   Parametrised program-counter generator for the pipelined core. Selects the next fetch

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_ras.sv | 90 +++++++++
 rtl/pc_ras_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter generator and its
// return-address stack.
package pc_pkg;

    // Source of the next fetch address, one value per next-PC rule.
    typedef enum logic [2:0] {
        SEL_HOLD,   // keep the current PC (stall or halt)
        SEL_INC,    // sequential fetch, addr + 1
        SEL_BR,     // taken branch from EX
        SEL_JMP,    // plain jump
        SEL_CALL,   // call: jump and push the return address
        SEL_RET,    // return served from the RAS top
        SEL_RETFB   // return with an empty RAS, use the fallback target
    } next_sel_t;

    // Top-level run/halt state. HALT is left only through reset.
    typedef enum logic {
        PC_RUN,
        PC_HALT
    } pc_state_t;

    localparam int unsigned ADDR_W_DEFAULT    = 16;
    localparam int unsigned RAS_DEPTH_DEFAULT = 4;
    localparam int unsigned RESET_PC_DEFAULT  = 0;

    // True when n is a power of two, so the RAS pointer can wrap naturally.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. The pointer always names the current top
// entry; a push writes one slot above it, and once the stack is full that
// slot is the oldest live entry, so it is overwritten and the overflow flag
// sticks until reset. DEPTH must be a power of two of at least 2 so pointer
// arithmetic wraps modulo DEPTH without extra logic.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned W     = ADDR_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         replace,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign top   = mem_q[ptr_q];
    assign ovf   = ovf_q;

    // Next pointer, count, overflow flag and write port for one stack operation.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;

        if (replace && !empty) begin
            // Call and return on the same edge: swap the top, depth unchanged.
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push || replace) begin
            // A replace on an empty stack degenerates to an ordinary push.
            wr_en  = 1'b1;
            wr_idx = ptr_q + PTR_W'(1);
            ptr_d  = ptr_q + PTR_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Stack bookkeeping registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the count alone decides which entries are live.
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ras_gen.sv
// Program-counter generator at the head of IF. Chooses the next fetch
// address from halt, branch, call, jump, return, hold or sequential
// increment (in that priority), keeps a return-address stack so returns
// redirect without a register read, and parks in a sticky HALT state.
// Every redirect lands on addr one cycle after the sampling edge.
module pc_ras_gen
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              hold,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic [ADDR_W-1:0] ret_addr,
    input  logic              ret,
    input  logic [ADDR_W-1:0] ret_fallback,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_plus,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf
);

    pc_state_t         state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    next_sel_t         sel;
    logic              ras_push, ras_pop, ras_replace;
    logic [ADDR_W-1:0] ras_top;

    assign addr      = addr_q;
    assign addr_plus = addr_q + ADDR_W'(1);
    assign halted    = (state_q == PC_HALT);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_replace),
        .push_data (ret_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf)
    );

    // Priority select of the next-PC source and the matching stack operation.
    always_comb begin
        sel         = SEL_INC;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;

        if (state_q == PC_HALT || hlt) begin
            // Halted, or halting on this edge: freeze PC and stack.
            sel = SEL_HOLD;
        end else if (br) begin
            // A taken branch flushes any call/return in flight; stack untouched.
            sel = SEL_BR;
        end else if (call) begin
            sel = SEL_CALL;
            if (ret) begin
                ras_replace = 1'b1;
            end else begin
                ras_push = 1'b1;
            end
        end else if (jump) begin
            sel = SEL_JMP;
        end else if (ret) begin
            if (!ras_empty) begin
                sel     = SEL_RET;
                ras_pop = 1'b1;
            end else begin
                sel = SEL_RETFB;
            end
        end else if (hold) begin
            sel = SEL_HOLD;
        end
    end

    // Next-PC mux driven by the selected source.
    always_comb begin
        case (sel)
            SEL_HOLD:  addr_d = addr_q;
            SEL_INC:   addr_d = addr_plus;
            SEL_BR:    addr_d = br_target;
            SEL_JMP:   addr_d = jump_target;
            SEL_CALL:  addr_d = jump_target;
            SEL_RET:   addr_d = ras_top;
            SEL_RETFB: addr_d = ret_fallback;
            default:   addr_d = addr_q;
        endcase
    end

    // Run/halt FSM and PC register; HALT is exited only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_RUN;
            addr_q  <= RESET_PC;
        end else begin
            addr_q <= addr_d;
            if (state_q == PC_RUN && hlt) begin
                state_q <= PC_HALT;
            end
        end
    end

endmodule
